tmds_encoder: RTL and testbench

- Per-channel TMDS 8b/10b encoder (DVI 1.0 algorithm).
- Sits between the vga timing/pixel generator and the 10:1 serializer inside the dvid output path. One instance per colour channel.
- Runs on vga_clk (pixel clock) and emits one 10-bit symbol per pixel clock.
- Pipelined, with a running-disparity counter to keep the line DC-balanced.

---
 rtl/tmds_encoder.sv | 169 ++++++++++++++++
 tb/tb_tmds_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// ---------------------------------------------------------------------------
// tmds_encoder
//   Per-channel TMDS 8b/10b encoder (DVI 1.0 algorithm) for the dvid output
//   path. One instance per colour channel, clocked by the pixel clock. Emits
//   one 10-bit symbol per clock and keeps a running disparity so the serial
//   line stays DC-balanced.
//
//   Pipeline: stage 1 builds the transition-minimised word q_m; stage 2
//   picks DC-balancing inversion and updates the disparity counter.
//   Latency from data/c0/c1/blank to dout is 2 clocks.
//
//   Optional build macro TMDS_OUTREG_EN: adds one more register on
//   dout/disparity for timing margin (latency 3 clocks, same symbols).
//
// Parameters:
//   CTRL_RESET  control code {c1,c0} whose symbol dout shows in reset.
//
// Ports:
//   clk        in   1   pixel clock
//   reset      in   1   synchronous active-high reset
//   data       in   8   pixel byte (ignored while blank=1)
//   c0, c1     in   1   control bits (hsync/vsync on blue channel)
//   blank      in   1   1 = control period, 0 = video data period
//   dout       out  10  TMDS symbol, bit 0 transmitted first
//   disparity  out  5   signed running disparity after current dout
// ---------------------------------------------------------------------------
module tmds_encoder #(
  parameter logic [1:0] CTRL_RESET = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       c0,
  input  logic       c1,
  input  logic       blank,
  output logic [9:0] dout,
  output logic [4:0] disparity
);

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = 10'b1101010100;
      2'b01:   sym = 10'b0010101011;
      2'b10:   sym = 10'b0101010100;
      default: sym = 10'b1010101011;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // ---------------------------------------------------------------- stage 1
  logic [3:0] n1d;
  logic       use_xnor;
  logic [7:0] chain;
  logic [8:0] q_m_next;

  logic [8:0] q_m_reg;
  logic       blank_d_reg;
  logic [1:0] c_d_reg;

  always_comb begin
    n1d = popcount8(data);
    // XNOR is chosen for byte values dense in ones; the tie at four ones
    // is broken on data[0] so the choice is deterministic.
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
    chain    = 8'h00;
    chain[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      chain[i] = use_xnor ? ~(chain[i-1] ^ data[i]) : (chain[i-1] ^ data[i]);
    end
    q_m_next = {~use_xnor, chain};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_m_reg     <= 9'd0;
      blank_d_reg <= 1'b1;
      c_d_reg     <= CTRL_RESET;
    end else begin
      q_m_reg     <= q_m_next;
      blank_d_reg <= blank;
      c_d_reg     <= {c1, c0};
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [3:0]        n1;
  logic [3:0]        n0;
  logic signed [4:0] diff;      // ones minus zeros of q_m[7:0], -8..+8
  logic signed [4:0] two_q8;    // 2*q_m[8]
  logic signed [4:0] two_nq8;   // 2*~q_m[8]
  logic              q8;

  logic [9:0]        dout_next;
  logic signed [4:0] cnt_next;
  logic [9:0]        dout_reg;
  logic signed [4:0] cnt_reg;

  always_comb begin
    q8      = q_m_reg[8];
    n1      = popcount8(q_m_reg[7:0]);
    n0      = 4'd8 - n1;
    diff    = $signed({1'b0, n1}) - $signed({1'b0, n0});
    two_q8  = $signed({3'b000, q8, 1'b0});
    two_nq8 = $signed({3'b000, ~q8, 1'b0});

    dout_next = dout_reg;
    cnt_next  = cnt_reg;

    if (blank_d_reg) begin
      // Control period resets the balance so every data run starts at 0.
      dout_next = ctrl_symbol(c_d_reg);
      cnt_next  = 5'sd0;
    end else if ((cnt_reg == 5'sd0) || (diff == 5'sd0)) begin
      dout_next = {~q8, q8, (q8 ? q_m_reg[7:0] : ~q_m_reg[7:0])};
      cnt_next  = q8 ? (cnt_reg + diff) : (cnt_reg - diff);
    end else if (((cnt_reg > 5'sd0) && (diff > 5'sd0)) ||
                 ((cnt_reg < 5'sd0) && (diff < 5'sd0))) begin
      // Running balance and this word lean the same way: invert to pull back.
      dout_next = {1'b1, q8, ~q_m_reg[7:0]};
      cnt_next  = cnt_reg + two_q8 - diff;
    end else begin
      dout_next = {1'b0, q8, q_m_reg[7:0]};
      cnt_next  = cnt_reg + diff - two_nq8;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_reg <= ctrl_symbol(CTRL_RESET);
      cnt_reg  <= 5'sd0;
    end else begin
      dout_reg <= dout_next;
      cnt_reg  <= cnt_next;
    end
  end

  // ---------------------------------------------------------------- output
`ifdef TMDS_OUTREG_EN
  logic [9:0] dout_out_reg;
  logic [4:0] disp_out_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_out_reg <= ctrl_symbol(CTRL_RESET);
      disp_out_reg <= 5'd0;
    end else begin
      dout_out_reg <= dout_reg;
      disp_out_reg <= cnt_reg;
    end
  end

  assign dout      = dout_out_reg;
  assign disparity = disp_out_reg;
`else
  assign dout      = dout_reg;
  assign disparity = cnt_reg;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_encoder
//   Self-checking bench for tmds_encoder. Directed steps (reset, control
//   codes, known data sequences, latency pulse, mid-stream reset) followed
//   by ~10k random pixels with periodic blank runs. Expected symbols come
//   from a behavioural model: a queue holds in-flight pixels, and the
//   running balance is tracked as the ones-minus-zeros of emitted symbols.
// ---------------------------------------------------------------------------
module tb_tmds_encoder;

`ifdef TMDS_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       c0;
  logic       c1;
  logic       blank;
  logic [9:0] dout;
  logic [4:0] disparity;

  always #5 clk = ~clk;

  tmds_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .c0        (c0),
    .c1        (c1),
    .blank     (blank),
    .dout      (dout),
    .disparity (disparity)
  );

  typedef struct {
    logic       b;
    logic [1:0] c;
    logic [7:0] d;
  } pix_t;

  int         total = 0;
  int         bad = 0;
  pix_t       pend[$];
  int         m_cnt;
  logic [9:0] exp_dout;
  bit         exp_is_data;
  logic [9:0] hist_dout[$];
  int         hist_disp[$];
  int         run_sum = 0;
  int         last_disp = 0;
  bit         in_run = 0;

  logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Encode one pixel; m_cnt follows the actual balance of emitted symbols.
  task automatic model_encode(input pix_t p, output logic [9:0] sym);
    int         ones_d;
    int         bal;
    logic [8:0] qm;
    bit         invert;
    if (p.b) begin
      sym   = ctrl_tab[p.c];
      m_cnt = 0;
      return;
    end
    ones_d = $countones(p.d);
    qm[8]  = !((ones_d > 4) || (ones_d == 4 && !p.d[0]));
    qm[0]  = p.d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = qm[8] ? (qm[i-1] ^ p.d[i]) : ~(qm[i-1] ^ p.d[i]);
    end
    bal = 2 * $countones(qm[7:0]) - 8;
    if (m_cnt == 0 || bal == 0) invert = !qm[8];
    else                        invert = ((m_cnt > 0) == (bal > 0));
    sym   = {invert, qm[8], (invert ? ~qm[7:0] : qm[7:0])};
    m_cnt = m_cnt + 2 * $countones(sym) - 10;
  endtask

  task automatic tick(input logic r, input logic b, input logic [1:0] c, input logic [7:0] d);
    pix_t       p;
    pix_t       e;
    logic [9:0] s;
    int         obs_disp;
    reset = r;
    blank = b;
    c1    = c[1];
    c0    = c[0];
    data  = d;
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
      for (int i = 0; i < LAT - 1; i++) pend.push_back('{1'b1, 2'b00, 8'h00});
      m_cnt       = 0;
      exp_dout    = ctrl_tab[0];
      exp_is_data = 1'b0;
    end else begin
      p = '{b, c, d};
      pend.push_back(p);
      e = pend.pop_front();
      model_encode(e, s);
      exp_dout    = s;
      exp_is_data = !e.b;
    end
    obs_disp = int'($signed(disparity));
    check("dout", dout, exp_dout);
    check_int("disparity", obs_disp, m_cnt);
    check_int("disp_range", int'(obs_disp >= -10 && obs_disp <= 10), 1);
    if (exp_is_data) begin
      run_sum   = run_sum + 2 * $countones(dout) - 10;
      last_disp = obs_disp;
      in_run    = 1'b1;
    end else if (in_run) begin
      check_int("run_balance", run_sum, last_disp);
      run_sum = 0;
      in_run  = 1'b0;
    end
    hist_dout.push_back(dout);
    hist_disp.push_back(obs_disp);
  endtask

  initial begin
    int         base;
    int         idx;
    int         n;
    int         blen;
    int         dlen;
    logic [1:0] cr;

    // Reset held three clocks in a control period.
    repeat (3) tick(1'b1, 1'b1, 2'b00, 8'h00);
    check("reset_dout", dout, 10'b1101010100);
    check_int("reset_disp", int'($signed(disparity)), 0);
    repeat (2) tick(1'b0, 1'b1, 2'b00, 8'h00);

    // Each control code, held long enough to pass through the pipeline.
    for (int k = 0; k < 4; k++) begin
      repeat (LAT + 1) tick(1'b0, 1'b1, 2'(k), 8'h5A);
      check("ctrl_code", dout, ctrl_tab[k]);
    end

    // Three zero bytes after blank, then back to blank.
    base = hist_dout.size();
    repeat (3) tick(1'b0, 1'b0, 2'b00, 8'h00);
    repeat (LAT) tick(1'b0, 1'b1, 2'b00, 8'h00);
    idx = base + LAT - 1;
    check("zero0_dout", hist_dout[idx], 10'b0100000000);
    check_int("zero0_disp", hist_disp[idx], -8);
    check("zero1_dout", hist_dout[idx+1], 10'b1111111111);
    check_int("zero1_disp", hist_disp[idx+1], 2);
    check("zero2_dout", hist_dout[idx+2], 10'b0100000000);
    check_int("zero2_disp", hist_disp[idx+2], -6);
    check("data_to_blank", hist_dout[idx+3], 10'b1101010100);

    // Single 0xFF pulse inside a blank run: latency and value.
    repeat (2) tick(1'b0, 1'b1, 2'b00, 8'h00);
    base = hist_dout.size();
    tick(1'b0, 1'b0, 2'b00, 8'hFF);
    repeat (LAT) tick(1'b0, 1'b1, 2'b00, 8'h00);
    idx = base + LAT - 1;
    check("pulse_before", hist_dout[idx-1], 10'b1101010100);
    check("pulse_dout", hist_dout[idx], 10'b1000000000);
    check_int("pulse_disp", hist_disp[idx], -8);
    check("pulse_after", hist_dout[idx+1], 10'b1101010100);

    // Reset asserted in the middle of a data stream.
    repeat (10) tick(1'b0, 1'b0, 2'b00, 8'($urandom));
    base = hist_dout.size();
    tick(1'b1, 1'b0, 2'b00, 8'($urandom));
    repeat (LAT) tick(1'b0, 1'b0, 2'b00, 8'($urandom));
    check("midreset_dout", hist_dout[base], 10'b1101010100);
    check_int("midreset_disp", hist_disp[base], 0);
    check("midreset_flush", hist_dout[base+1], 10'b1101010100);
    check_int("midreset_flush_disp", hist_disp[base+1], 0);

    // Random pixels with periodic blank runs.
    n = 0;
    while (n < 10000) begin
      blen = $urandom_range(1, 8);
      cr   = 2'($urandom);
      repeat (blen) tick(1'b0, 1'b1, cr, 8'($urandom));
      dlen = $urandom_range(1, 60);
      repeat (dlen) tick(1'b0, 1'b0, 2'($urandom), 8'($urandom));
      n = n + blen + dlen;
    end
    repeat (LAT + 1) tick(1'b0, 1'b1, 2'b00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
